output_layer_mac: RTL

Sequential multiply-accumulate engine for the 10-neuron output layer of the digit-recognition network. It consumes the hidden-layer activation vector and the static weight/bias buses produced by `output_layer_param`, and computes one signed score per digit class, one MAC per cycle. It also reports the argmax class as the recognised digit. It sits between the hidden-layer stage and the result/display logic.

---
 rtl/output_layer_mac.sv | 133 +++++++++++++
 1 files changed

// File: rtl/output_layer_mac.sv
// output_layer_mac: sequential MAC engine for the 10-neuron output layer.
// Computes one signed score per digit class, one MAC per cycle, and reports
// the argmax class. done/digit are registered off the DONE state, so they
// appear in the cycle after DONE, which is the first IDLE cycle of the next
// inference. busy is stretched over that cycle so that it covers done.
module output_layer_mac #(
    parameter int unsigned N_IN      = 30,
    parameter int unsigned N_OUT     = 10,
    parameter int unsigned W         = 8,
    parameter int unsigned FRAC_BITS = 5,
    parameter int unsigned ACC_W     = 24
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [W*N_IN-1:0]         hidden_act,
    input  logic [W*N_OUT*N_IN-1:0]   weights_HL,
    input  logic [W*N_OUT-1:0]        biases_HL,
    output logic                      busy,
    output logic                      done,
    output logic [ACC_W*N_OUT-1:0]    scores,
    output logic [3:0]                digit
);

    localparam int unsigned I_W = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam int unsigned J_W = (N_IN > 1) ? $clog2(N_IN + 1) : 1;
    localparam int unsigned P_W = 2 * W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_BIAS,
        S_MAC,
        S_STORE,
        S_DONE
    } state_t;

    state_t state, next_state;

    logic [W*N_IN-1:0]       act_q;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] max_q;
    logic [3:0]              idx_q;
    logic [I_W-1:0]          i_q;
    logic [J_W-1:0]          j_q;

    logic signed [W-1:0]     w_sel;
    logic signed [W-1:0]     a_sel;
    logic signed [W-1:0]     b_sel;
    logic signed [P_W-1:0]   prod;
    logic signed [ACC_W-1:0] bias_ext;

    // Operand selection: current weight, captured activation, bias and product
    always_comb begin
        w_sel    = weights_HL[(int'(i_q) * N_IN + int'(j_q)) * W +: W];
        a_sel    = act_q[int'(j_q) * W +: W];
        b_sel    = biases_HL[int'(i_q) * W +: W];
        prod     = w_sel * a_sel;
        bias_ext = ACC_W'(b_sel) <<< FRAC_BITS;
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (start) next_state = S_BIAS;
            S_BIAS:  next_state = S_MAC;
            S_MAC:   if (j_q == J_W'(N_IN - 1)) next_state = S_STORE;
            S_STORE: next_state = (i_q == I_W'(N_OUT - 1)) ? S_DONE : S_BIAS;
            S_DONE:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Datapath, argmax tracking and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            act_q  <= '0;
            acc    <= '0;
            max_q  <= '0;
            idx_q  <= '0;
            i_q    <= '0;
            j_q    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            scores <= '0;
            digit  <= '0;
        end else begin
            busy <= (next_state != S_IDLE) || (state == S_DONE);
            done <= (state == S_DONE);
            case (state)
                S_IDLE: begin
                    if (start) begin
                        act_q <= hidden_act;
                        i_q   <= '0;
                        j_q   <= '0;
                    end
                end
                S_BIAS: begin
                    acc <= bias_ext;
                    j_q <= '0;
                end
                S_MAC: begin
                    acc <= acc + ACC_W'(prod);
                    j_q <= j_q + J_W'(1);
                end
                S_STORE: begin
                    scores[int'(i_q) * ACC_W +: ACC_W] <= acc;
                    if ((i_q == '0) || (acc > max_q)) begin
                        max_q <= acc;
                        idx_q <= 4'(i_q);
                    end
                    if (i_q != I_W'(N_OUT - 1)) begin
                        i_q <= i_q + I_W'(1);
                    end
                end
                S_DONE: begin
                    digit <= idx_q;
                end
                default: ;
            endcase
        end
    end

endmodule
